// File: rtl/jtcop_obj_scan.sv
// Per-line object scheduler: walks the 256-entry object table on every line start and issues
// one draw command per vertically visible object. Optional per-line draw cap: JTCOP_OBJ_LIMIT_EN.
module jtcop_obj_scan #(
  parameter int         MAXOBJ  = 32,
  parameter logic [8:0] HOFFSET = 9'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LHBL,
  input  logic [8:0]  vrender,
  input  logic        flip,
  output logic [9:0]  tbl_addr,
  input  logic [15:0] tbl_dout,
  output logic        draw,
  input  logic        draw_busy,
  output logic [11:0] tile_id,
  output logic [3:0]  veff,
  output logic        hflip,
  output logic [3:0]  pal,
  output logic [8:0]  hpos,
  output logic        scan_done
);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    CHECK,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t      st, st_nxt;
  logic [7:0]  obj, obj_nxt;
  logic [9:0]  addr_nxt;
  logic        lhbl_l;
  logic        line_start;
  logic        issue;
  logic        limit_hit;

  // decoded fields of the entry being processed
  logic        e_en, e_fy, e_fx;
  logic [1:0]  e_h;
  logic [8:0]  e_y;
  logic [11:0] e_code;
  logic [3:0]  e_pal;
  logic [8:0]  e_x;

  logic [8:0]  ydiff;
  logic [9:0]  span;
  logic        visible;
  logic [2:0]  row_mask, row_raw, row;
  logic        vflip;
  logic [3:0]  veff_c;
  logic [11:0] tile_c;
  logic [8:0]  hx, hpos_c;

  assign line_start = lhbl_l & ~LHBL;

  // vertical coverage and row selection within the object
  always_comb begin
    ydiff   = vrender - e_y;
    span    = 10'd16 << e_h;
    visible = e_en && ({1'b0, ydiff} < span);
    case (e_h)
      2'd0:    row_mask = 3'd0;
      2'd1:    row_mask = 3'd1;
      2'd2:    row_mask = 3'd3;
      default: row_mask = 3'd7;
    endcase
    row_raw = ydiff[6:4] & row_mask;
    vflip   = e_fy ^ flip;
    row     = vflip ? (row_mask - row_raw) : row_raw;
    veff_c  = vflip ? ~ydiff[3:0] : ydiff[3:0];
    tile_c  = e_code + {9'd0, row};
    hx      = flip ? (9'd496 - e_x) : e_x;
    hpos_c  = hx + HOFFSET;
  end

`ifdef JTCOP_OBJ_LIMIT_EN
  logic [8:0] draw_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      draw_cnt <= 9'd0;
    end else if (line_start) begin
      draw_cnt <= 9'd0;
    end else if (issue) begin
      draw_cnt <= draw_cnt + 9'd1;
    end
  end

  assign limit_hit = int'(draw_cnt) >= MAXOBJ;
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    st_nxt  = st;
    obj_nxt = obj;
    issue   = 1'b0;
    case (st)
      IDLE:  st_nxt = IDLE;
      RD0:   st_nxt = RD1;
      RD1:   st_nxt = RD2;
      RD2:   st_nxt = CHECK;
      CHECK: st_nxt = visible ? ISSUE : WAIT;
      ISSUE: begin
        if (!draw_busy) begin
          issue  = 1'b1;
          st_nxt = WAIT;
        end
      end
      WAIT: begin
        if (obj == 8'hff || limit_hit) begin
          st_nxt = DONE;
        end else begin
          obj_nxt = obj + 8'd1;
          st_nxt  = RD0;
        end
      end
      DONE:    st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
    // a new line aborts whatever is in flight
    if (line_start) begin
      st_nxt  = RD0;
      obj_nxt = 8'd0;
      issue   = 1'b0;
    end
    case (st_nxt)
      RD0:     addr_nxt = {obj_nxt, 2'd0};
      RD1:     addr_nxt = {obj_nxt, 2'd1};
      RD2:     addr_nxt = {obj_nxt, 2'd2};
      default: addr_nxt = tbl_addr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      obj       <= 8'd0;
      lhbl_l    <= 1'b0;
      tbl_addr  <= 10'd0;
      draw      <= 1'b0;
      tile_id   <= 12'd0;
      veff      <= 4'd0;
      hflip     <= 1'b0;
      pal       <= 4'd0;
      hpos      <= 9'd0;
      scan_done <= 1'b1;
      e_en      <= 1'b0;
      e_fy      <= 1'b0;
      e_fx      <= 1'b0;
      e_h       <= 2'd0;
      e_y       <= 9'd0;
      e_code    <= 12'd0;
      e_pal     <= 4'd0;
      e_x       <= 9'd0;
    end else begin
      st       <= st_nxt;
      obj      <= obj_nxt;
      lhbl_l   <= LHBL;
      tbl_addr <= addr_nxt;
      draw     <= issue;
      // RAM data trails its address by one clock
      case (st)
        RD1: begin
          e_en <= tbl_dout[15];
          e_fy <= tbl_dout[14];
          e_fx <= tbl_dout[13];
          e_h  <= tbl_dout[12:11];
          e_y  <= tbl_dout[8:0];
        end
        RD2:   e_code <= tbl_dout[11:0];
        CHECK: begin
          e_pal <= tbl_dout[15:12];
          e_x   <= tbl_dout[8:0];
        end
        default: ;
      endcase
      if (issue) begin
        tile_id <= tile_c;
        veff    <= veff_c;
        hflip   <= e_fx ^ flip;
        pal     <= e_pal;
        hpos    <= hpos_c;
      end
      if (line_start) begin
        scan_done <= 1'b0;
      end else if (st_nxt == DONE) begin
        scan_done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/jtcop_obj_scan.md
Name: jtcop_obj_scan

Overview:
- Per-line object scheduler for the sprite draw unit.
- On each line start it walks the 256-entry object table in object RAM, one 4-word entry per object, and decodes each entry.
- It checks vertical coverage of the line being rendered; for each visible object it issues one draw command (tile code, row, flip, palette, x) to the draw unit, handshaking on draw_busy.
- Sits between object RAM and the draw/line-buffer block.

Parameters:
- MAXOBJ, 32: maximum draw commands per line (only used with JTCOP_OBJ_LIMIT_EN).
- HOFFSET, 9'd0: constant added mod 512 to the object x before issue.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- LHBL  in  1  horizontal blank, active low; falling edge = line start
- vrender  in  9  line being prepared
- flip  in  1  global screen flip
- tbl_addr  out  10  object RAM word address {obj[7:0], word[1:0]}
- tbl_dout  in  16  object RAM data, valid 1 clk after tbl_addr
- draw  out  1  one-cycle draw request
- draw_busy  in  1  draw unit busy
- tile_id  out  12  tile code with row offset applied
- veff  out  4  row inside the 16-px tile
- hflip  out  1  horizontal flip
- pal  out  4  palette
- hpos  out  9  x start
- scan_done  out  1  high once the table walk for this line is finished

Behaviour:
- Reset values: tbl_addr=0, draw=0, tile_id=0, veff=0, hflip=0, pal=0, hpos=0, scan_done=1. State is IDLE.
- Entry format:
  - w0: [15] enable, [14] flipy, [13] flipx, [12:11] height code h (1/2/4/8 tiles of 16 px), [8:0] y.
  - w1: [11:0] code.
  - w2: [15:12] pal, [8:0] x.
  - w3: ignored, never read.
- States: IDLE -> RD0 -> RD1 -> RD2 -> CHECK -> ISSUE -> WAIT -> next object (RD0) or DONE.
- Line start: LHBL 1->0, detected with a registered copy of LHBL. Then obj=0 and scan_done=0, go to RD0. This happens from any state, so a scan in progress aborts and restarts at object 0. A draw already pulsed is not retracted.
- RD0/RD1/RD2: drive word 0, 1, 2 in turn. Each word is latched from tbl_dout one clk after its address is driven.
- CHECK:
  - ydiff = (vrender - y) mod 512, 9 bits.
  - Visible when enable=1 and ydiff < 16<<h.
  - row = ydiff[6:4] masked to h bits. When flipy XOR flip, row = (2^h-1) - row and veff = ~ydiff[3:0]; otherwise veff = ydiff[3:0].
  - tile_id = code + row, 12-bit wrap.
  - Not visible: skip ISSUE.
- ISSUE:
  - Wait while draw_busy=1.
  - Then latch tile_id, veff, hflip = flipx XOR flip, pal, and hpos = (flip ? 9'd496 - x : x) + HOFFSET mod 512.
  - Pulse draw for exactly one clk, then go to WAIT.
- WAIT: one clk of guard so the draw unit can raise draw_busy. Command outputs hold until the next ISSUE.
- Next object:
  - obj==255 -> DONE: scan_done=1, then IDLE.
  - Otherwise obj+1 and go to RD0.
- Throughput: a skipped object costs 5 clk.
- draw is never asserted while draw_busy=1 in the same cycle.

Optional Feature:
- Macro JTCOP_OBJ_LIMIT_EN.
- Defined: a per-line counter (reset at line start) counts issued draws. When it reaches MAXOBJ, the scan goes straight to DONE and later entries are not drawn.
- Undefined: no counter; all visible objects are issued.

Test Plan:
- Single object: obj0 w0=0x8064 (en, y=100, h=0), w1=0x123, w2=0x5040, vrender=105 -> one draw, tile_id=0x123, veff=5, pal=5, hpos=0x040, hflip=0.
- Tall object with flipy: w0=0xD064 (h=2, 64 px), vrender=100+37 -> row 2 flipped gives row=1, tile_id=code+1, veff=~5=10.
- Busy handshake: draw_busy held high 40 clk with two visible objects -> second draw only after draw_busy falls; draw never coincides with draw_busy=1.
- Disabled or out-of-range entries: all enable=0 -> no draw; scan_done rises 5*256 clk after line start (±2).
- Restart: new LHBL falling edge mid-scan at obj 100 -> tbl_addr returns to 0 next clk, scan_done=0.
- Limit: with JTCOP_OBJ_LIMIT_EN and MAXOBJ=32, 40 visible objects -> exactly 32 draws. Without the macro -> 40 draws.
- Reset mid-scan: rst_n low -> draw=0, scan_done=1 immediately.
